reg_bank_arbiter: RTL and testbench

- Two-client arbiter and sequencer for a bank of 16-bit load-enabled registers.
- Each client issues single-word read or write requests. The block arbitrates round-robin, drives the per-register load strobe for exactly one clock, and returns read data with a done pulse.
- Sits between the CPU-side requesters and the register storage; it is the only agent allowed to assert any register's load.

---
 rtl/reg_bank_arbiter_pkg.sv | 15 +
 rtl/reg_bank_arbiter_reg_bank.sv | 44 ++++
 rtl/reg_bank_arbiter.sv | 109 ++++++++++
 tb/tb_reg_bank_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// rtl/reg_bank_arbiter_pkg.sv - shared constants and FSM encoding for the register bank arbiter
// Contents: bank geometry defaults (WIDTH, NREG, AW) and the sequencer state type.
package reg_bank_arbiter_pkg;

  localparam int WIDTH = 16;
  localparam int NREG  = 8;
  localparam int AW    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/reg_bank_arbiter_reg_bank.sv
// rtl/reg_bank_arbiter_reg_bank.sv - bank of NREG load-enabled registers with one-hot load decode and read mux
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-high clear of every register
//   load         : write strobe for the register selected by addr
//   addr         : register index for both write and read
//   din          : write data
//   dout         : combinational read data of register addr
module reg_bank #(
  parameter int WIDTH = reg_bank_arbiter_pkg::WIDTH,
  parameter int NREG  = reg_bank_arbiter_pkg::NREG,
  parameter int AW    = reg_bank_arbiter_pkg::AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  import reg_bank_arbiter_pkg::*;

  logic [NREG-1:0]            ld;
  logic [NREG-1:0][WIDTH-1:0] regs;

  // At most one load line is ever active: the decode is gated by the single strobe.
  always_comb begin
    ld = '0;
    if (load) ld[addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (ld[i]) regs[i] <= din;
      end
    end
  end

  assign dout = regs[addr];

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - two-client round-robin arbiter and sequencer for a register bank
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   req0/req1           : level requests, held until the matching done pulse
//   we0/we1             : 1 = write, 0 = read; sampled on the grant edge
//   addr0/addr1         : register index; sampled on the grant edge
//   in0/in1             : write data; sampled on the grant edge
//   gnt0/gnt1           : one-cycle pulse, request accepted (ACCESS cycle)
//   done0/done1         : one-cycle pulse, transaction complete (DONE cycle)
//   out                 : data of the most recently completed read
module reg_bank_arbiter #(
  parameter int WIDTH = reg_bank_arbiter_pkg::WIDTH,
  parameter int NREG  = reg_bank_arbiter_pkg::NREG,
  parameter int AW    = reg_bank_arbiter_pkg::AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] in0,
  output logic             gnt0,
  output logic             done0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt1,
  output logic             done1,
  output logic [WIDTH-1:0] out
);

  import reg_bank_arbiter_pkg::*;

  state_t           state;
  logic             last;        // client granted most recently
  logic             cmd_client;
  logic             cmd_we;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_data;
  logic             pick1;
  logic             load;
  logic [WIDTH-1:0] rdata;

  // Client 1 wins when it is alone, or on a tie when client 0 was served last.
  assign pick1 = req1 & (~req0 | ~last);

  // The bank is written only from the latched command, and only in ACCESS.
  assign load = (state == ST_ACCESS) && cmd_we;

  reg_bank #(
    .WIDTH(WIDTH),
    .NREG (NREG),
    .AW   (AW)
  ) u_bank (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .addr (cmd_addr),
    .din  (cmd_data),
    .dout (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last       <= 1'b1;   // makes client 0 the first tie winner
      cmd_client <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      out        <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 | req1) begin
            cmd_client <= pick1;
            cmd_we     <= pick1 ? we1   : we0;
            cmd_addr   <= pick1 ? addr1 : addr0;
            cmd_data   <= pick1 ? in1   : in0;
            gnt0       <= ~pick1;
            gnt1       <= pick1;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!cmd_we) out <= rdata;
          done0 <= ~cmd_client;
          done1 <= cmd_client;
          state <= ST_DONE;
        end
        ST_DONE: begin
          last  <= cmd_client;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [2:0]  addr0, addr1;
  logic [15:0] in0, in1;
  logic        gnt0, done0, gnt1, done1;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .req0 (req0),
    .we0  (we0),
    .addr0(addr0),
    .in0  (in0),
    .gnt0 (gnt0),
    .done0(done0),
    .req1 (req1),
    .we1  (we1),
    .addr1(addr1),
    .in1  (in1),
    .gnt1 (gnt1),
    .done1(done1),
    .out  (out)
  );

  typedef struct {
    logic        c;
    logic        we;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_client(input int c, input logic rq, input logic we,
                            input logic [2:0] a, input logic [15:0] d);
    if (c == 0) begin
      req0 = rq; we0 = we; addr0 = a; in0 = d;
    end else begin
      req1 = rq; we1 = we; addr1 = a; in1 = d;
    end
  endtask

  task automatic drop_req(input int c);
    if (c == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    set_client(0, 1'b0, 1'b0, 3'd0, 16'h0);
    set_client(1, 1'b0, 1'b0, 3'd0, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns the granted client and the number of negedges waited.
  task automatic wait_grant(output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        cyc = i;
        who = gnt1 ? 1 : 0;
        chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
        chk("done_during_gnt", {30'd0, done0, done1}, 32'd0);
        break;
      end
    end
    if (who < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: no gnt within 8 cycles");
      drop_req(0);
      drop_req(1);
    end
  endtask

  // Called at the grant negedge; ends at the done negedge.
  task automatic finish_txn(input int who, input logic [15:0] exp_out,
                            input bit drop, input bit scramble);
    logic [15:0] rd;
    logic [2:0]  ra;
    logic        rw;
    if (scramble) begin
      rd = 16'($urandom);
      ra = 3'($urandom);
      rw = 1'($urandom);
      set_client(who, 1'b1, rw, ra, rd);
    end
    @(negedge clk);
    chk("done_winner", {31'd0, (who == 0) ? done0 : done1}, 32'd1);
    chk("done_other",  {31'd0, (who == 0) ? done1 : done0}, 32'd0);
    chk("out", {16'd0, out}, {16'd0, exp_out});
    if (drop) drop_req(who);
  endtask

  task automatic do_single(input int c, input logic we, input logic [2:0] a,
                           input logic [15:0] d, input logic [15:0] exp_out);
    int who, cyc;
    @(negedge clk);
    set_client(c, 1'b1, we, a, d);
    wait_grant(who, cyc);
    if (who >= 0) begin
      chk("gnt_client", who, c);
      chk("gnt_latency", cyc, 1);
      finish_txn(who, exp_out, 1'b1, 1'b1);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      do_single(int'(vt[i].c), vt[i].we, vt[i].a, vt[i].d, vt[i].exp_out);
  endtask

  initial begin
    int who, cyc, seen;
    logic [15:0] mem_m [8];
    logic [15:0] out_m;
    int          last_m, exp_w;
    bit          pending [2];
    logic        pw [2];
    logic [2:0]  pa [2];
    logic [15:0] pd [2];

    vt[0] = '{1'b0, 1'b1, 3'd3, 16'ha000, 16'h0000};
    vt[1] = '{1'b0, 1'b0, 3'd3, 16'h0000, 16'ha000};
    vt[2] = '{1'b1, 1'b1, 3'd5, 16'h0030, 16'ha000};
    vt[3] = '{1'b1, 1'b0, 3'd5, 16'h0000, 16'h0030};
    vt[4] = '{1'b0, 1'b0, 3'd1, 16'h0000, 16'h0a00};
    vt[5] = '{1'b1, 1'b0, 3'd2, 16'h0000, 16'h000f};
    vt[6] = '{1'b0, 1'b0, 3'd1, 16'h0000, 16'h0a00};
    vt[7] = '{1'b0, 1'b1, 3'd1, 16'he000, 16'h0a00};
    vt[8] = '{1'b1, 1'b0, 3'd1, 16'h0000, 16'he000};

    reset = 1'b1;
    set_client(0, 1'b0, 1'b0, 3'd0, 16'h0);
    set_client(1, 1'b0, 1'b0, 3'd0, 16'h0);
    repeat (2) @(negedge clk);
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_done0", {31'd0, done0}, 32'd0);
    chk("rst_done1", {31'd0, done1}, 32'd0);
    chk("rst_out", {16'd0, out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic write/read and input change after grant (scrambled in finish_txn).
    run_vecs(0, 3);

    // Simultaneous requests after reset: client 0 first, then client 1.
    do_reset();
    @(negedge clk);
    set_client(0, 1'b1, 1'b1, 3'd1, 16'h0a00);
    set_client(1, 1'b1, 1'b1, 3'd2, 16'h000f);
    wait_grant(who, cyc);
    chk("sim_first", who, 0);
    if (who >= 0) finish_txn(who, 16'h0000, 1'b1, 1'b0);
    wait_grant(who, cyc);
    chk("sim_second", who, 1);
    chk("sim_spacing", cyc, 2);
    if (who >= 0) finish_txn(who, 16'h0000, 1'b1, 1'b0);
    drop_req(0);
    drop_req(1);

    // Reads of both, then out holds across a write and idle cycles.
    run_vecs(4, 7);
    repeat (4) begin
      @(negedge clk);
      chk("out_hold", {16'd0, out}, 32'h0a00);
    end
    run_vecs(8, 8);

    // Fairness: both requests held for six transactions.
    do_reset();
    @(negedge clk);
    set_client(0, 1'b1, 1'b1, 3'd0, 16'h1111);
    set_client(1, 1'b1, 1'b1, 3'd6, 16'h2222);
    for (int k = 0; k < 6; k++) begin
      wait_grant(who, cyc);
      chk("fair_order", who, k % 2);
      chk("fair_spacing", cyc, (k == 0) ? 1 : 2);
      if (who < 0) break;
      finish_txn(who, 16'h0000, 1'b0, 1'b0);
    end
    drop_req(0);
    drop_req(1);
    do_single(0, 1'b0, 3'd0, 16'h0, 16'h1111);
    do_single(1, 1'b0, 3'd6, 16'h0, 16'h2222);

    // Reset during ACCESS discards the write and suppresses done.
    do_single(0, 1'b0, 3'd7, 16'h0, 16'h0000);
    @(negedge clk);
    set_client(0, 1'b1, 1'b1, 3'd7, 16'h0070);
    wait_grant(who, cyc);
    chk("racc_gnt", who, 0);
    reset = 1'b1;
    req0  = 1'b0;
    #1;
    chk("racc_gnt_clear", {31'd0, gnt0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done0 | done1) seen++;
    end
    chk("racc_no_done", seen, 0);
    chk("racc_out", {16'd0, out}, 32'h0);
    do_single(0, 1'b0, 3'd7, 16'h0, 16'h0000);

    // Randomized traffic against a transaction-level model.
    do_reset();
    for (int i = 0; i < 8; i++) mem_m[i] = 16'h0;
    out_m   = 16'h0;
    last_m  = 1;
    pending = '{0, 0};
    for (int r = 0; r < 300; r++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (!pending[c] && $urandom_range(0, 2) != 0) begin
          pending[c] = 1'b1;
          pw[c] = 1'($urandom_range(0, 1));
          pa[c] = 3'($urandom_range(0, 7));
          pd[c] = 16'($urandom);
          set_client(c, 1'b1, pw[c], pa[c], pd[c]);
        end
      end
      if (!pending[0] && !pending[1]) continue;
      if (pending[0] && pending[1]) exp_w = (last_m == 0) ? 1 : 0;
      else                          exp_w = pending[1] ? 1 : 0;
      wait_grant(who, cyc);
      chk("rnd_winner", who, exp_w);
      chk("rnd_latency", cyc, 1);
      if (who < 0) break;
      if (pw[exp_w]) mem_m[pa[exp_w]] = pd[exp_w];
      else           out_m = mem_m[pa[exp_w]];
      last_m = exp_w;
      pending[exp_w] = 1'b0;
      finish_txn(exp_w, out_m, 1'b1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
